mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_issue_pkg.sv | 29 ++
 rtl/mul_issue_ctrl_if.sv | 54 +++++
 rtl/mul_issue_fifo.sv | 66 ++++++
 rtl/mul_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_issue_pkg.sv
// Shared types and constants for the multiply issue controller.
// Holds operand/result widths, default parameters and the FSM state encoding.
package mul_issue_pkg;

    localparam int unsigned OPND_W           = 64;
    localparam int unsigned RES_W            = 128;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;
    localparam int unsigned DEF_DONE_TIMEOUT = 100;

    // Controller states, kept as plain constants for compatibility with older tools.
    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StLoad  = 3'd1;
    localparam state_t StRun   = 3'd2;
    localparam state_t StClear = 3'd3;
    localparam state_t StOut   = 3'd4;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } pair_t;

    function automatic logic [RES_W-1:0] pack_pair(input logic [OPND_W-1:0] a,
                                                   input logic [OPND_W-1:0] b);
        return {a, b};
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Bundle of the operand intake, multiply-unit and result handshake signals.
// The master modport is the controller's view; slave is the surrounding environment.
interface mul_issue_ctrl_if;
    import mul_issue_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OPND_W-1:0] in_a;
    logic [OPND_W-1:0] in_b;

    logic [OPND_W-1:0] multiplier;
    logic [OPND_W-1:0] multiplicand;
    logic              op_start;
    logic              op_clear;
    logic              op_done;
    logic [RES_W-1:0]  mul_result;

    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;

    modport master (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  op_done,
        input  mul_result,
        input  res_ready,
        output in_ready,
        output multiplier,
        output multiplicand,
        output op_start,
        output op_clear,
        output res_valid,
        output res_data
    );

    modport slave (
        output in_valid,
        output in_a,
        output in_b,
        output op_done,
        output mul_result,
        output res_ready,
        input  in_ready,
        input  multiplier,
        input  multiplicand,
        input  op_start,
        input  op_clear,
        input  res_valid,
        input  res_data
    );

endinterface

// File: rtl/mul_issue_fifo.sv
// Synchronous operand-pair queue; DEPTH must be a power of two so pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
module mul_issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues queued operand pairs to an external multiply unit and returns products in order.
// Define MUL_ISSUE_TIMEOUT_EN to abort a run after DONE_TIMEOUT cycles without op_done.
module mul_issue_ctrl
    import mul_issue_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    mul_issue_ctrl_if.master        bus,
    output logic                    busy,
    output logic                    timeout_err
);

    state_t            state_q;
    state_t            state_d;
    logic [OPND_W-1:0] opnd_a_q;
    logic [OPND_W-1:0] opnd_b_q;
    logic [RES_W-1:0]  res_data_q;
    logic              res_valid_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    pair_t             head;
    logic [RES_W-1:0]  head_raw;

    logic              timeout_hit;
    logic              abort;

    assign fifo_push = bus.in_valid && bus.in_ready;
    assign head      = pair_t'(head_raw);

    mul_issue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (pack_pair(bus.in_a, bus.in_b)),
        .pop   (fifo_pop),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MUL_ISSUE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(DONE_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_err_q;
    logic             abort_q;

    // Fires in the last permitted RUN cycle if op_done has still not arrived.
    assign timeout_hit = (state_q == StRun) && !bus.op_done &&
                         (tmo_cnt_q == TMO_W'(DONE_TIMEOUT - 1));
    assign abort       = abort_q;
    assign timeout_err = timeout_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            if (state_q == StLoad) begin
                tmo_cnt_q <= '0;
            end else if (state_q == StRun) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
                abort_q       <= 1'b1;
            end else if (state_q == StClear) begin
                abort_q <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty && !res_valid_q) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                fifo_pop = 1'b1;
                state_d  = StRun;
            end
            StRun: begin
                if (bus.op_done || timeout_hit) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = abort ? StIdle : StOut;
            end
            StOut: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            opnd_a_q    <= '0;
            opnd_b_q    <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StLoad) begin
                opnd_a_q <= head.a;
                opnd_b_q <= head.b;
            end
            // The product is only valid in the op_done cycle, so capture it there.
            if ((state_q == StRun) && bus.op_done) begin
                res_data_q <= bus.mul_result;
            end
            if ((state_q == StClear) && !abort) begin
                res_valid_q <= 1'b1;
            end else if ((state_q == StOut) && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = !fifo_full;
    assign bus.multiplier   = opnd_a_q;
    assign bus.multiplicand = opnd_b_q;
    assign bus.op_start     = (state_q == StRun);
    assign bus.op_clear     = (state_q == StClear);
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: directed scenarios plus a randomized run
// scored against an in-order queue of accepted operand pairs.
module tb_mul_issue_ctrl;
    import mul_issue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 100;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
    } pr_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic timeout_err;

    mul_issue_ctrl_if bus ();

    mul_issue_ctrl #(
        .FIFO_DEPTH   (DEPTH),
        .DONE_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  passed = 0;
    int  fails = 0;
    pr_t exp_q[$];

    // Multiply unit model: raises op_done in the done_delay-th RUN cycle.
    int  done_delay = 10;
    bit  no_done = 1'b0;
    bit  rand_delay = 1'b0;
    int  run_cnt = 0;
    int  clear_cnt = 0;

    always @(negedge clk) begin
        if (bus.op_clear) clear_cnt++;
        if (bus.op_start && !reset) begin
            run_cnt++;
            if (rand_delay && run_cnt == 1) done_delay = $urandom_range(1, 20);
            if (!no_done && run_cnt == done_delay) begin
                bus.op_done    = 1'b1;
                bus.mul_result = 128'(bus.multiplier) * 128'(bus.multiplicand);
            end else begin
                bus.op_done    = 1'b0;
                bus.mul_result = {$urandom, $urandom, $urandom, $urandom};
            end
        end else begin
            run_cnt        = 0;
            bus.op_done    = 1'b0;
            bus.mul_result = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    function automatic logic [127:0] prod(input pr_t p);
        return 128'(p.a) * 128'(p.b);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] a, input logic [63:0] b, output bit acc);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        acc          = bus.in_ready;
        step();
        bus.in_valid = 1'b0;
        if (acc) exp_q.push_back('{a: a, b: b});
    endtask

    logic [127:0] last_res;

    task automatic wait_res(input string tag);
        int  n;
        pr_t p;
        n = 0;
        bus.res_ready = 1'b1;
        while (!bus.res_valid && n < 2000) begin
            step();
            n++;
        end
        if (!bus.res_valid) begin
            check({tag, "_wait"}, 128'(bus.res_valid), 128'd1);
        end else begin
            p        = exp_q.pop_front();
            last_res = bus.res_data;
            check(tag, bus.res_data, prod(p));
            step();
        end
        bus.res_ready = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!bus.op_start && n < 50) begin
            step();
            n++;
        end
        if (!bus.op_start) check({tag, "_start"}, 128'(bus.op_start), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        int rc;
        int base;
        int pushes_left;
        pr_t p;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_res_valid", 128'(bus.res_valid), 128'd0);
        check("rst_op_start", 128'(bus.op_start), 128'd0);
        check("rst_op_clear", 128'(bus.op_clear), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_timeout", 128'(timeout_err), 128'd0);
        check("rst_res_data", bus.res_data, 128'd0);
        check("rst_operands", {bus.multiplier, bus.multiplicand}, 128'd0);

        // Single op 3*5 with 64 RUN cycles, plus latency
        done_delay = 64;
        base = clear_cnt;
        offer(64'd3, 64'd5, acc);
        check("t1_accept", 128'(acc), 128'd1);
        check("t1_idle_after_push", 128'(busy), 128'd0);
        step();
        check("t1_load_busy", 128'(busy), 128'd1);
        check("t1_load_no_start", 128'(bus.op_start), 128'd0);
        step();
        check("t1_run_start", 128'(bus.op_start), 128'd1);
        check("t1_operands", {bus.multiplier, bus.multiplicand}, {64'd3, 64'd5});
        rc = 0;
        n  = 0;
        while (!bus.op_clear && n < 500) begin
            if (bus.op_start) rc++;
            step();
            n++;
        end
        check("t1_run_cycles", 128'(rc), 128'd64);
        check("t1_clear", 128'(bus.op_clear), 128'd1);
        check("t1_no_valid_in_clear", 128'(bus.res_valid), 128'd0);
        step();
        check("t1_valid", 128'(bus.res_valid), 128'd1);
        check("t1_clear_done", 128'(bus.op_clear), 128'd0);
        check("t1_data", bus.res_data, 128'd15);
        check("t1_clear_pulses", 128'(clear_cnt - base), 128'd1);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t1_valid_dropped", 128'(bus.res_valid), 128'd0);
        void'(exp_q.pop_front());

        // Back-pressure with a second op queued
        done_delay = 5;
        offer(64'd7, 64'd9, acc);
        offer(64'd11, 64'd13, acc);
        n = 0;
        while (!bus.res_valid && n < 200) begin
            step();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 128'(bus.res_valid), 128'd1);
            check("bp_data", bus.res_data, 128'd63);
            check("bp_no_start", 128'(bus.op_start), 128'd0);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("bp_valid_dropped", 128'(bus.res_valid), 128'd0);
        void'(exp_q.pop_front());
        wait_res("bp_second");

        // Full queue: one op running, 4 queued, 6th rejected
        done_delay = 30;
        offer($urandom, $urandom, acc);
        wait_start("fq");
        for (int i = 2; i <= 5; i++) begin
            offer({$urandom, $urandom}, {$urandom, $urandom}, acc);
            check("fq_accept", 128'(acc), 128'd1);
        end
        check("fq_ready_low", 128'(bus.in_ready), 128'd0);
        offer(64'hDEAD, 64'hBEEF, acc);
        check("fq_reject", 128'(acc), 128'd0);
        for (int i = 0; i < 5; i++) wait_res("fq_res");
        repeat (5) step();
        check("fq_drained_busy", 128'(busy), 128'd0);
        check("fq_drained_valid", 128'(bus.res_valid), 128'd0);

        // Max operands
        done_delay = 3;
        offer(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, acc);
        wait_res("max_res");
        check("max_literal", last_res, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        // Randomized traffic against the in-order queue
        rand_delay  = 1'b1;
        pushes_left = 16;
        n = 0;
        while ((pushes_left > 0 || exp_q.size() > 0) && n < 3000) begin
            if (pushes_left > 0 && $urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b1;
                bus.in_a     = {$urandom, $urandom};
                bus.in_b     = {$urandom, $urandom};
                if (bus.in_ready) begin
                    exp_q.push_back('{a: bus.in_a, b: bus.in_b});
                    pushes_left--;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.res_ready = ($urandom_range(0, 2) != 0);
            if (bus.op_start && exp_q.size() > 0) begin
                p = exp_q[0];
                check("rnd_operands", {bus.multiplier, bus.multiplicand}, {p.a, p.b});
            end
            if (bus.res_valid && bus.res_ready) begin
                p = exp_q.pop_front();
                check("rnd_res", bus.res_data, prod(p));
            end
            step();
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        rand_delay    = 1'b0;
        check("rnd_all_results", 128'(exp_q.size()), 128'd0);
        exp_q.delete();

`ifdef MUL_ISSUE_TIMEOUT_EN
        // Timeout: first op never completes, second proceeds
        no_done = 1'b1;
        base    = clear_cnt;
        offer(64'd21, 64'd22, acc);
        offer(64'd23, 64'd24, acc);
        void'(exp_q.pop_front());
        wait_start("tmo");
        rc = 0;
        n  = 0;
        while (!bus.op_clear && n < 500) begin
            if (bus.op_start) rc++;
            step();
            n++;
        end
        no_done    = 1'b0;
        done_delay = 4;
        check("tmo_run_cycles", 128'(rc), 128'(TMO));
        check("tmo_clear", 128'(bus.op_clear), 128'd1);
        check("tmo_err", 128'(timeout_err), 128'd1);
        step();
        check("tmo_no_valid", 128'(bus.res_valid), 128'd0);
        check("tmo_clear_pulses", 128'(clear_cnt - base), 128'd1);
        wait_res("tmo_next");
        check("tmo_sticky", 128'(timeout_err), 128'd1);
`else
        check("tmo_tied_low", 128'(timeout_err), 128'd0);
`endif

        // Reset in RUN discards in-flight and queued work
        done_delay = 50;
        offer(64'd31, 64'd32, acc);
        offer(64'd33, 64'd34, acc);
        wait_start("rr");
        repeat (3) step();
        base  = clear_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rr_op_start", 128'(bus.op_start), 128'd0);
        check("rr_res_valid", 128'(bus.res_valid), 128'd0);
        check("rr_in_ready", 128'(bus.in_ready), 128'd1);
        check("rr_busy", 128'(busy), 128'd0);
        check("rr_operands", {bus.multiplier, bus.multiplicand}, 128'd0);
        repeat (5) step();
        check("rr_fifo_empty", 128'(busy), 128'd0);
        check("rr_no_clear", 128'(clear_cnt - base), 128'd0);
        exp_q.delete();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
